// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the data memory bus and its lane aligner.
package mem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_ILL  = 2'b11
   } memSize_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_RESP = 2'b10
   } memState_e;

   // Per-byte write enables for an access of the given size at a byte offset.
   function automatic logic [3:0] byteEnables(input logic [1:0] size, input logic [1:0] offset);
      logic [3:0] base;
      case (size)
         SZ_BYTE: base = 4'b0001;
         SZ_HALF: base = 4'b0011;
         SZ_WORD: base = 4'b1111;
         default: base = 4'b0000;
      endcase
      return base << offset;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Load-lane extraction: pulls a byte/half/word out of a 32-bit word and extends it.
module mem_lane_align import mem_pkg::*; (
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        isUnsigned,
   output logic [31:0] result
);

   logic [31:0] shifted;

   always_comb begin
      // NOTE: every output gets a default first so no path through the case can infer a latch.
      shifted = word >> {offset, 3'b000};
      result  = shifted;
      case (size)
         SZ_BYTE: result = {{24{~isUnsigned & shifted[7]}}, shifted[7:0]};
         SZ_HALF: result = {{16{~isUnsigned & shifted[15]}}, shifted[15:0]};
         default: result = shifted;
      endcase
   end

endmodule

// File: rtl/data_memory_bus.sv
// Data memory with valid/ready requests, configurable wait states and access checking.
module data_memory_bus import mem_pkg::*; #(
   parameter int    DEPTH       = 256,
   parameter int    WAIT_STATES = 0,
   parameter string INIT_FILE   = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_error
);

   localparam int         AW       = $clog2(DEPTH);
   localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   memState_e   state;
   logic [3:0]  count;
   logic        capWrite, capUnsigned;
   logic [1:0]  capSize;
   logic [31:0] capAddr, capWdata;

   logic        accept, enterResp, opErr;
   logic        opWrite, opUnsigned;
   logic [1:0]  opSize;
   logic [31:0] opAddr, opWdata, wdataShifted, memWord, loadData;
   logic [3:0]  opBe;
   logic [AW-1:0] wordIdx;

   // NOTE: storage has no reset on purpose; contents survive rst like a real SRAM.
   logic [31:0] mem [DEPTH];

   assign accept = req_valid && req_ready;

   // With zero wait states the commit edge is the accept edge, so live inputs are used.
   assign opWrite    = (state == ST_WAIT) ? capWrite    : req_write;
   assign opSize     = (state == ST_WAIT) ? capSize     : req_size;
   assign opUnsigned = (state == ST_WAIT) ? capUnsigned : req_unsigned;
   assign opAddr     = (state == ST_WAIT) ? capAddr     : req_addr;
   assign opWdata    = (state == ST_WAIT) ? capWdata    : req_wdata;

   assign enterResp = (state == ST_WAIT) ? (count == 4'd0) : (accept && (WAIT_STATES == 0));

   assign opErr = (opSize == SZ_ILL)
                || (opSize == SZ_HALF && opAddr[0])
                || (opSize == SZ_WORD && opAddr[1:0] != 2'b00)
                || (|opAddr[31:AW+2]);

   assign wordIdx      = opAddr[AW+1:2];
   assign opBe         = byteEnables(opSize, opAddr[1:0]);
   assign wdataShifted = opWdata << {opAddr[1:0], 3'b000};
   assign memWord      = mem[wordIdx];

   mem_lane_align uAlign (
      .word       (memWord),
      .offset     (opAddr[1:0]),
      .size       (opSize),
      .isUnsigned (opUnsigned),
      .result     (loadData)
   );

   always_ff @(posedge clk) begin
      if (enterResp && opWrite && !opErr) begin
         for (int b = 0; b < 4; b++) begin
            if (opBe[b]) mem[wordIdx][8*b +: 8] <= wdataShifted[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_IDLE;
         count       <= 4'd0;
         req_ready   <= 1'b1;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= 32'd0;
         rsp_error   <= 1'b0;
         capWrite    <= 1'b0;
         capSize     <= 2'b00;
         capUnsigned <= 1'b0;
         capAddr     <= 32'd0;
         capWdata    <= 32'd0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         rsp_valid <= 1'b0;
         if (accept) begin
            capWrite    <= req_write;
            capSize     <= req_size;
            capUnsigned <= req_unsigned;
            capAddr     <= req_addr;
            capWdata    <= req_wdata;
         end
         case (state)
            ST_IDLE, ST_RESP: begin
               if (accept) begin
                  if (WAIT_STATES == 0) begin
                     state <= ST_RESP;
                  end else begin
                     state     <= ST_WAIT;
                     count     <= CNT_LOAD;
                     req_ready <= 1'b0;
                  end
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_WAIT: begin
               if (count == 4'd0) begin
                  state     <= ST_RESP;
                  req_ready <= 1'b1;
               end else begin
                  count <= count - 4'd1;
               end
            end
            default: begin
               state     <= ST_IDLE;
               req_ready <= 1'b1;
            end
         endcase
         if (enterResp) begin
            rsp_valid <= 1'b1;
            rsp_error <= opErr;
            rsp_rdata <= (opErr || opWrite) ? 32'd0 : loadData;
         end
      end
   end

endmodule
